// File: rtl/cpu7_exu_bru.sv
// Branch resolution unit: evaluates E-stage branches, holds a redirect request
// toward the IFU until it is acked or flushed. Optional: CPU7_BRU_ADEF_EN.
module cpu7_exu_bru (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_exu_valid_d,
  input  logic [31:0] ifu_exu_pc_d,
  input  logic [31:0] ifu_exu_br_offs,
  input  logic [3:0]  ifu_exu_br_type_d,
  input  logic [31:0] exu_bru_rj_e,
  input  logic [31:0] exu_bru_rd_e,
  input  logic        exu_bru_stall_e,
  input  logic        exu_bru_flush,
  input  logic        ifu_bru_redirect_ack,
  output logic        bru_ifu_redirect_vld,
  output logic [31:0] bru_ifu_redirect_pc,
  output logic        bru_exu_link_vld,
  output logic [31:0] bru_exu_link_data,
  output logic        bru_exu_busy,
  output logic [31:0] bru_exu_redir_cnt
`ifdef CPU7_BRU_ADEF_EN
  ,
  output logic        bru_exu_excp_ade,
  output logic [31:0] bru_exu_badv
`endif
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_REQ  = 1'b1;

  localparam logic [3:0] T_BEQ  = 4'd1;
  localparam logic [3:0] T_BNE  = 4'd2;
  localparam logic [3:0] T_BLT  = 4'd3;
  localparam logic [3:0] T_BGE  = 4'd4;
  localparam logic [3:0] T_BLTU = 4'd5;
  localparam logic [3:0] T_BGEU = 4'd6;
  localparam logic [3:0] T_B    = 4'd7;
  localparam logic [3:0] T_BL   = 4'd8;
  localparam logic [3:0] T_JIRL = 4'd9;

  logic        state;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_offs;
  logic [3:0]  e_type;
  logic [31:0] redir_pc;
  logic [31:0] redir_cnt;

  logic        taken;
  logic        is_jirl;
  logic        resolve;
  logic        redir_fire;
  logic [31:0] tgt_raw;
  logic [31:0] target;
`ifdef CPU7_BRU_ADEF_EN
  logic        ade_fire;
  logic        ade_q;
  logic [31:0] badv_q;
`endif

  always_comb begin
    taken = 1'b0;
    case (e_type)
      T_BEQ:              taken = (exu_bru_rj_e == exu_bru_rd_e);
      T_BNE:              taken = (exu_bru_rj_e != exu_bru_rd_e);
      T_BLT:              taken = ($signed(exu_bru_rj_e) <  $signed(exu_bru_rd_e));
      T_BGE:              taken = ($signed(exu_bru_rj_e) >= $signed(exu_bru_rd_e));
      T_BLTU:             taken = (exu_bru_rj_e <  exu_bru_rd_e);
      T_BGEU:             taken = (exu_bru_rj_e >= exu_bru_rd_e);
      T_B, T_BL, T_JIRL:  taken = 1'b1;
      default:            taken = 1'b0;
    endcase
  end

  assign is_jirl = (e_type == T_JIRL);
  assign tgt_raw = is_jirl ? (exu_bru_rj_e + e_offs) : (e_pc + e_offs);
  assign resolve = (state == S_IDLE) && e_valid && taken
                   && !exu_bru_stall_e && !exu_bru_flush;

`ifdef CPU7_BRU_ADEF_EN
  // Misaligned JIRL targets raise an address exception instead of redirecting.
  assign ade_fire   = resolve && is_jirl && (tgt_raw[1:0] != 2'b00);
  assign redir_fire = resolve && !ade_fire;
  assign target     = tgt_raw;
`else
  assign redir_fire = resolve;
  assign target     = is_jirl ? {tgt_raw[31:2], 2'b00} : tgt_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      redir_pc  <= '0;
      redir_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redir_fire) begin
            state    <= S_REQ;
            redir_pc <= target;
          end
        end
        default: begin
          // Flush wins over a coincident ack: request dropped, not counted.
          if (exu_bru_flush) begin
            state <= S_IDLE;
          end else if (ifu_bru_redirect_ack) begin
            state     <= S_IDLE;
            redir_cnt <= redir_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_pc    <= '0;
      e_offs  <= '0;
      e_type  <= '0;
    end else if ((state == S_IDLE) && !exu_bru_stall_e) begin
      e_valid <= ifu_exu_valid_d && !exu_bru_flush && !redir_fire;
      e_pc    <= ifu_exu_pc_d;
      e_offs  <= ifu_exu_br_offs;
      e_type  <= ifu_exu_br_type_d;
    end else if (exu_bru_flush) begin
      e_valid <= 1'b0;
    end
  end

`ifdef CPU7_BRU_ADEF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ade_q  <= 1'b0;
      badv_q <= '0;
    end else begin
      ade_q <= ade_fire;
      if (ade_fire) begin
        badv_q <= tgt_raw;
      end
    end
  end

  assign bru_exu_excp_ade = ade_q;
  assign bru_exu_badv     = badv_q;
`endif

  assign bru_ifu_redirect_vld = (state == S_REQ);
  assign bru_ifu_redirect_pc  = redir_pc;
  assign bru_exu_busy         = (state == S_REQ);
  assign bru_exu_redir_cnt    = redir_cnt;
  assign bru_exu_link_vld     = e_valid && ((e_type == T_BL) || (e_type == T_JIRL));
  assign bru_exu_link_data    = e_pc + 32'd4;

endmodule

// File: tb/tb_cpu7_exu_bru.sv
// Self-checking bench for cpu7_exu_bru: directed scenarios plus random traffic
// against a cycle-level reference model. Honours CPU7_BRU_ADEF_EN if defined.
module tb_cpu7_exu_bru;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_exu_valid_d;
  logic [31:0] ifu_exu_pc_d;
  logic [31:0] ifu_exu_br_offs;
  logic [3:0]  ifu_exu_br_type_d;
  logic [31:0] exu_bru_rj_e;
  logic [31:0] exu_bru_rd_e;
  logic        exu_bru_stall_e;
  logic        exu_bru_flush;
  logic        ifu_bru_redirect_ack;
  logic        bru_ifu_redirect_vld;
  logic [31:0] bru_ifu_redirect_pc;
  logic        bru_exu_link_vld;
  logic [31:0] bru_exu_link_data;
  logic        bru_exu_busy;
  logic [31:0] bru_exu_redir_cnt;
`ifdef CPU7_BRU_ADEF_EN
  logic        bru_exu_excp_ade;
  logic [31:0] bru_exu_badv;
`endif

  cpu7_exu_bru dut (
    .clk                  (clk),
    .reset                (reset),
    .ifu_exu_valid_d      (ifu_exu_valid_d),
    .ifu_exu_pc_d         (ifu_exu_pc_d),
    .ifu_exu_br_offs      (ifu_exu_br_offs),
    .ifu_exu_br_type_d    (ifu_exu_br_type_d),
    .exu_bru_rj_e         (exu_bru_rj_e),
    .exu_bru_rd_e         (exu_bru_rd_e),
    .exu_bru_stall_e      (exu_bru_stall_e),
    .exu_bru_flush        (exu_bru_flush),
    .ifu_bru_redirect_ack (ifu_bru_redirect_ack),
    .bru_ifu_redirect_vld (bru_ifu_redirect_vld),
    .bru_ifu_redirect_pc  (bru_ifu_redirect_pc),
    .bru_exu_link_vld     (bru_exu_link_vld),
    .bru_exu_link_data    (bru_exu_link_data),
    .bru_exu_busy         (bru_exu_busy),
    .bru_exu_redir_cnt    (bru_exu_redir_cnt)
`ifdef CPU7_BRU_ADEF_EN
    ,
    .bru_exu_excp_ade     (bru_exu_excp_ade),
    .bru_exu_badv         (bru_exu_badv)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: the instruction sitting in E, the pending redirect, counters.
  bit          m_ev;
  logic [31:0] m_pc, m_offs;
  logic [3:0]  m_type;
  bit          m_req;
  logic [31:0] m_tgt, m_cnt;
  bit          m_ade;
  logic [31:0] m_badv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void outcome(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] offs,
                                  input logic [31:0] rj, input logic [31:0] rd,
                                  output bit tk, output logic [31:0] tgt);
    longint srj, srd;
    srj = longint'($signed(rj));
    srd = longint'($signed(rd));
    case (t)
      4'd1: tk = (rj == rd);
      4'd2: tk = (rj != rd);
      4'd3: tk = (srj <  srd);
      4'd4: tk = (srj >= srd);
      4'd5: tk = (longint'(rj) <  longint'(rd));
      4'd6: tk = (longint'(rj) >= longint'(rd));
      4'd7, 4'd8, 4'd9: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tgt = (t == 4'd9) ? 32'((64'(rj) + 64'(offs)) % 64'h1_0000_0000)
                      : 32'((64'(pc) + 64'(offs)) % 64'h1_0000_0000);
  endfunction

  function automatic void model_clear();
    m_ev = 0; m_pc = '0; m_offs = '0; m_type = '0;
    m_req = 0; m_tgt = '0; m_cnt = '0; m_ade = 0; m_badv = '0;
  endfunction

  function automatic void model_step();
    bit          tk, fire, was_req;
    logic [31:0] tgt;
    if (reset) begin
      model_clear();
      return;
    end
    fire = 0;
    was_req = m_req;
    m_ade = 0;
    if (!m_req && m_ev && !exu_bru_stall_e && !exu_bru_flush) begin
      outcome(m_type, m_pc, m_offs, exu_bru_rj_e, exu_bru_rd_e, tk, tgt);
      if (tk) begin
        if (m_type == 4'd9 && tgt[1:0] != 2'b00) begin
`ifdef CPU7_BRU_ADEF_EN
          m_ade = 1; m_badv = tgt;
`else
          fire = 1; tgt[1:0] = 2'b00;
`endif
        end else begin
          fire = 1;
        end
      end
    end
    if (was_req) begin
      if (exu_bru_flush) m_req = 0;
      else if (ifu_bru_redirect_ack) begin m_req = 0; m_cnt = m_cnt + 32'd1; end
    end else if (fire) begin
      m_req = 1; m_tgt = tgt;
    end
    if (!was_req && !exu_bru_stall_e) begin
      m_ev = ifu_exu_valid_d && !exu_bru_flush && !fire;
      m_pc = ifu_exu_pc_d; m_offs = ifu_exu_br_offs; m_type = ifu_exu_br_type_d;
    end else if (exu_bru_flush) begin
      m_ev = 0;
    end
  endfunction

  task automatic check_outputs();
    bit lv;
    lv = m_ev && (m_type == 4'd8 || m_type == 4'd9);
    chk("busy", 32'(bru_exu_busy), 32'(m_req));
    chk("redir_vld", 32'(bru_ifu_redirect_vld), 32'(m_req));
    chk("redir_pc", bru_ifu_redirect_pc, m_tgt);
    chk("redir_cnt", bru_exu_redir_cnt, m_cnt);
    chk("link_vld", 32'(bru_exu_link_vld), 32'(lv));
    if (lv) chk("link_data", bru_exu_link_data, m_pc + 32'd4);
`ifdef CPU7_BRU_ADEF_EN
    chk("excp_ade", 32'(bru_exu_excp_ade), 32'(m_ade));
    chk("badv", bru_exu_badv, m_badv);
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_d(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] offs);
    ifu_exu_valid_d   = 1'b1;
    ifu_exu_br_type_d = t;
    ifu_exu_pc_d      = pc;
    ifu_exu_br_offs   = offs;
    tick();
    ifu_exu_valid_d   = 1'b0;
    ifu_exu_br_type_d = 4'd0;
  endtask

  task automatic do_ack();
    ifu_bru_redirect_ack = 1'b1;
    tick();
    ifu_bru_redirect_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifu_exu_valid_d = 0; ifu_exu_pc_d = '0; ifu_exu_br_offs = '0; ifu_exu_br_type_d = '0;
    exu_bru_rj_e = '0; exu_bru_rd_e = '0; exu_bru_stall_e = 0; exu_bru_flush = 0;
    ifu_bru_redirect_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(bru_exu_busy), 32'd0);
    chk("rst_pc", bru_ifu_redirect_pc, 32'd0);
    chk("rst_cnt", bru_exu_redir_cnt, 32'd0);

    // BEQ taken
    put_d(4'd1, 32'h1C000100, 32'h40);
    exu_bru_rj_e = 32'd5; exu_bru_rd_e = 32'd5;
    tick();
    chk("beq_vld", 32'(bru_ifu_redirect_vld), 32'd1);
    chk("beq_pc", bru_ifu_redirect_pc, 32'h1C000140);
    do_ack();
    chk("beq_cnt", bru_exu_redir_cnt, 32'd1);
    chk("beq_idle", 32'(bru_exu_busy), 32'd0);

    // BLTU not taken, BLT taken with the same operands
    put_d(4'd5, 32'h1C000000, 32'h80);
    exu_bru_rj_e = 32'hFFFFFFFF; exu_bru_rd_e = 32'd1;
    tick();
    chk("bltu_nt", 32'(bru_ifu_redirect_vld), 32'd0);
    chk("bltu_busy", 32'(bru_exu_busy), 32'd0);
    put_d(4'd3, 32'h1C000000, 32'h80);
    tick();
    chk("blt_tk", 32'(bru_ifu_redirect_vld), 32'd1);
    chk("blt_pc", bru_ifu_redirect_pc, 32'h1C000080);
    do_ack();

    // BL with late ack
    put_d(4'd8, 32'h1C000200, 32'h100);
    chk("bl_link_vld", 32'(bru_exu_link_vld), 32'd1);
    chk("bl_link", bru_exu_link_data, 32'h1C000204);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bl_busy", 32'(bru_exu_busy), 32'd1);
      chk("bl_pc", bru_ifu_redirect_pc, 32'h1C000300);
      if (i < 3) tick();
    end
    do_ack();
    chk("bl_cnt", bru_exu_redir_cnt, 32'd3);

    // flush and ack together while requesting
    put_d(4'd7, 32'h1C001000, 32'h10);
    tick();
    chk("fa_busy", 32'(bru_exu_busy), 32'd1);
    exu_bru_flush = 1; ifu_bru_redirect_ack = 1;
    tick();
    exu_bru_flush = 0; ifu_bru_redirect_ack = 0;
    chk("fa_idle", 32'(bru_exu_busy), 32'd0);
    chk("fa_cnt", bru_exu_redir_cnt, 32'd3);

    // flush coincident with a taken resolve
    put_d(4'd1, 32'h1C002000, 32'h20);
    exu_bru_rj_e = 32'd9; exu_bru_rd_e = 32'd9; exu_bru_flush = 1;
    tick();
    exu_bru_flush = 0;
    chk("fr_vld", 32'(bru_ifu_redirect_vld), 32'd0);

    // misaligned JIRL
    put_d(4'd9, 32'h1C003000, 32'h0);
    exu_bru_rj_e = 32'h1C000003;
    tick();
`ifdef CPU7_BRU_ADEF_EN
    chk("jirl_ade", 32'(bru_exu_excp_ade), 32'd1);
    chk("jirl_badv", bru_exu_badv, 32'h1C000003);
    chk("jirl_vld", 32'(bru_ifu_redirect_vld), 32'd0);
    tick();
`else
    chk("jirl_vld", 32'(bru_ifu_redirect_vld), 32'd1);
    chk("jirl_pc", bru_ifu_redirect_pc, 32'h1C000000);
    do_ack();
`endif

    // target wrap-around
    put_d(4'd7, 32'hFFFFFFFC, 32'h8);
    tick();
    chk("wrap_pc", bru_ifu_redirect_pc, 32'h00000004);
    do_ack();

    // reset while requesting, ack low
    put_d(4'd7, 32'h1C004000, 32'h4);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rreq_busy", 32'(bru_exu_busy), 32'd0);
    chk("rreq_cnt", bru_exu_redir_cnt, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      ifu_exu_valid_d      = ($urandom_range(0, 1) == 1);
      ifu_exu_br_type_d    = 4'($urandom_range(0, 15));
      ifu_exu_pc_d         = $urandom & 32'hFFFFFFFC;
      ifu_exu_br_offs      = 32'($signed(16'($urandom))) <<< 2;
      exu_bru_rj_e         = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      exu_bru_rd_e         = ($urandom_range(0, 2) == 0) ? exu_bru_rj_e : $urandom;
      exu_bru_stall_e      = ($urandom_range(0, 4) == 0);
      exu_bru_flush        = ($urandom_range(0, 9) == 0);
      ifu_bru_redirect_ack = ($urandom_range(0, 2) == 0);
      reset                = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cpu7_exu_bru.md
CPU7_EXU_BRU -- requirements
Module: cpu7_exu_bru

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit, a synchronous, active-high reset.
REQ-003 The block SHALL have the port ifu_exu_valid_d, input, 1 bit, a valid instruction in the decode (D) stage.
REQ-004 The block SHALL have the port ifu_exu_pc_d, input, 32 bits, the PC of the D instruction.
REQ-005 The block SHALL have the port ifu_exu_br_offs, input, 32 bits, the branch offset: sign-extended and already shifted left by 2.
REQ-006 The block SHALL have the port ifu_exu_br_type_d, input, 4 bits: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 B, 8 BL, 9 JIRL; values 10-15 are treated as none.
REQ-007 The block SHALL have the ports exu_bru_rj_e and exu_bru_rd_e, input, 32 bits each, the source operand values for the E-stage instruction.
REQ-008 The block SHALL have the port exu_bru_stall_e, input, 1 bit, which holds the E stage.
REQ-009 The block SHALL have the port exu_bru_flush, input, 1 bit, a kill from an older instruction.
REQ-010 The block SHALL have the port ifu_bru_redirect_ack, input, 1 bit, the IFU's acceptance of a redirect.
REQ-011 The block SHALL have the ports bru_ifu_redirect_vld (output, 1 bit) and bru_ifu_redirect_pc (output, 32 bits), the redirect request and its target.
REQ-012 The block SHALL have the ports bru_exu_link_vld (output, 1 bit) and bru_exu_link_data (output, 32 bits), the BL/JIRL link value, equal to the E-stage PC+4.
REQ-013 The block SHALL have the port bru_exu_busy, output, 1 bit, which tells upstream to stall D.
REQ-014 The block SHALL have the port bru_exu_redir_cnt, output, 32 bits, a count of redirects issued.
REQ-015 The block SHALL have the ports bru_exu_excp_ade (output, 1 bit) and bru_exu_badv (output, 32 bits), which exist only under CPU7_BRU_ADEF_EN.

Function
REQ-016 The block SHALL capture the D-to-E register {valid, pc, offs, type} on a cycle when exu_bru_stall_e=0 and the state is IDLE; it SHALL hold the register when stalled.
REQ-017 The block SHALL evaluate branch conditions on rj vs rd: EQ, NE, signed LT/GE, unsigned LTU/GEU; types B, BL and JIRL are always taken.
REQ-018 The block SHALL compute the target as pc_e+offs for types 1-8 and rj+offs for JIRL, using 32-bit wrap-around addition.
REQ-019 The block SHALL assert bru_exu_link_vld combinationally while E is valid and of type BL or JIRL, with link_data=pc_e+4.
REQ-020 A valid, taken, unstalled, unflushed E instruction in cycle N SHALL cause redirect_vld=1 with the registered target in cycle N+1.
REQ-021 The state machine SHALL have two states, IDLE and REQ: IDLE->REQ on a taken resolve; REQ->IDLE on ack or flush; REQ is held otherwise, with redirect_pc stable.
REQ-022 The block SHALL drive bru_exu_busy=1 exactly while in REQ; D capture SHALL be blocked and E SHALL be invalidated on entry to REQ.
REQ-023 When ack and flush arrive in the same cycle, flush SHALL take priority: the request is dropped and the counter is not incremented.
REQ-024 A flush SHALL clear E-valid next cycle; a flush in IDLE coincident with a taken resolve SHALL suppress the redirect.
REQ-025 The block SHALL increment redir_cnt by 1 on each REQ->IDLE transition caused by ack, wrapping from 0xFFFFFFFF to 0.
REQ-026 Not-taken branches and non-branch instructions SHALL produce no redirect and no busy.

Reset
REQ-027 On reset, state SHALL be IDLE, E-valid 0, redirect_vld 0, redirect_pc 0, busy 0, redir_cnt 0, excp_ade 0 and badv 0.
REQ-028 Reset during REQ SHALL abandon the request in the next cycle regardless of ack.

Configuration
REQ-029 With CPU7_BRU_ADEF_EN defined, a JIRL target with [1:0]!=0 SHALL NOT redirect; instead excp_ade SHALL pulse for 1 cycle at N+1 with badv=target.
REQ-030 Without CPU7_BRU_ADEF_EN, the excp_ade and badv ports SHALL be absent and the JIRL target SHALL have bits [1:0] forced to 00, then redirect normally.

Verification
REQ-031 BEQ, pc=0x1C000100, offs=0x40, rj=rd=5 -> redirect_vld next cycle, pc=0x1C000140; ack -> IDLE, redir_cnt=1.
REQ-032 BLTU, rj=0xFFFFFFFF, rd=1 -> not taken, no redirect; BLT with the same operands -> taken.
REQ-033 BL at pc=0x1C000200, ack held low for 3 cycles -> busy=1 and redirect_pc stable for 4 cycles, link_data=0x1C000204.
REQ-034 Taken branch with flush and ack in the same cycle while in REQ -> IDLE, redir_cnt unchanged.
REQ-035 JIRL, rj=0x1C000003, offs=0 -> with CPU7_BRU_ADEF_EN: excp_ade=1, badv=0x1C000003, no redirect; without it: redirect to 0x1C000000.
REQ-036 B at pc=0xFFFFFFFC, offs=0x8 -> target 0x00000004, wrapping; redir_cnt preset to 0xFFFFFFFF via repeated redirects -> wraps to 0.
